// File: rtl/team_03_wb_pkg.sv
// team_03_wb_pkg: register offsets, default window base and byte-lane helpers for team_03_wb_regs.
package team_03_wb_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;

    localparam logic [7:0] OFF_OUT_LO  = 8'h00;
    localparam logic [7:0] OFF_OUT_HI  = 8'h04;
    localparam logic [7:0] OFF_OEB_LO  = 8'h08;
    localparam logic [7:0] OFF_OEB_HI  = 8'h0C;
    localparam logic [7:0] OFF_IN_LO   = 8'h10;
    localparam logic [7:0] OFF_IN_HI   = 8'h14;
    localparam logic [7:0] OFF_EDGE_LO = 8'h18;
    localparam logic [7:0] OFF_EDGE_HI = 8'h1C;
    localparam logic [7:0] OFF_SCRATCH = 8'h20;

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [31:0] m);
        return (old & ~m) | (d & m);
    endfunction

endpackage

// File: rtl/team_03_sync2.sv
// team_03_sync2: parameterized-width two-flop synchronizer, cleared by reset.
module team_03_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/team_03_wb_regs.sv
// team_03_wb_regs: Wishbone classic GPIO register block for the team_03 breakout.
// Define TEAM_03_WB_ERR_EN to add wbs_err_o and answer unmapped in-window offsets with err.
module team_03_wb_regs
    import team_03_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          GPIO_W    = 34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
`ifdef TEAM_03_WB_ERR_EN
    output logic              wbs_err_o,
`endif
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oeb
);

    generate
        if (GPIO_W < 33 || GPIO_W > 64) begin : g_bad_width
            $error("GPIO_W must be within 33..64");
        end
    endgenerate

    // Pin registers are held 64 bits wide; bits at and above GPIO_W are masked to 0.
    localparam logic [63:0] PIN_M = (64'd1 << GPIO_W) - 64'd1;

    logic [63:0]       out_q, oeb_q, edge_q, out_n, oeb_n, edge_n, clr, in_w, rise_w;
    logic [31:0]       scratch_q, scratch_n, mask, rdata;
    logic [GPIO_W-1:0] in_s, in_d;
    logic [7:0]        off;
    logic              hit, req, mapped, unused;

    assign off    = {wbs_adr_i[7:2], 2'b00};
    assign unused = ^wbs_adr_i[1:0];
    assign hit    = wbs_adr_i[31:8] == BASE_ADDR[31:8];
    assign req    = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    assign mapped = off <= OFF_SCRATCH;
    assign mask   = sel_mask(wbs_sel_i);
    assign in_w   = 64'(in_s);
    assign rise_w = 64'(in_s & ~in_d);

    team_03_sync2 #(.W(GPIO_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_in),
        .q   (in_s)
    );

    always_comb begin
        rdata = '0;
        case (off)
            OFF_OUT_LO:  rdata = out_q[31:0];
            OFF_OUT_HI:  rdata = out_q[63:32];
            OFF_OEB_LO:  rdata = oeb_q[31:0];
            OFF_OEB_HI:  rdata = oeb_q[63:32];
            OFF_IN_LO:   rdata = in_w[31:0];
            OFF_IN_HI:   rdata = in_w[63:32];
            OFF_EDGE_LO: rdata = edge_q[31:0];
            OFF_EDGE_HI: rdata = edge_q[63:32];
            OFF_SCRATCH: rdata = scratch_q;
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        out_n     = out_q;
        oeb_n     = oeb_q;
        scratch_n = scratch_q;
        clr       = '0;
        if (req && wbs_we_i) begin
            case (off)
                OFF_OUT_LO:  out_n[31:0]     = merge(out_q[31:0], wbs_dat_i, mask);
                OFF_OUT_HI:  out_n[63:32]    = merge(out_q[63:32], wbs_dat_i, mask);
                OFF_OEB_LO:  oeb_n[31:0]     = merge(oeb_q[31:0], wbs_dat_i, mask);
                OFF_OEB_HI:  oeb_n[63:32]    = merge(oeb_q[63:32], wbs_dat_i, mask);
                OFF_EDGE_LO: clr[31:0]       = wbs_dat_i & mask;
                OFF_EDGE_HI: clr[63:32]      = wbs_dat_i & mask;
                OFF_SCRATCH: scratch_n       = merge(scratch_q, wbs_dat_i, mask);
                default:     scratch_n       = scratch_q;
            endcase
        end
        // A rising edge in the same cycle as its clear keeps the flag set.
        edge_n = ((edge_q & ~clr) | rise_w) & PIN_M;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbs_ack_o <= 1'b0;
`ifdef TEAM_03_WB_ERR_EN
            wbs_err_o <= 1'b0;
`endif
            wbs_dat_o <= '0;
            out_q     <= '0;
            oeb_q     <= PIN_M;
            edge_q    <= '0;
            scratch_q <= '0;
            in_d      <= '0;
        end else begin
`ifdef TEAM_03_WB_ERR_EN
            wbs_ack_o <= req & mapped;
            wbs_err_o <= req & ~mapped;
`else
            wbs_ack_o <= req;
`endif
            wbs_dat_o <= (req & mapped) ? rdata : '0;
            out_q     <= out_n & PIN_M;
            oeb_q     <= oeb_n & PIN_M;
            edge_q    <= edge_n;
            scratch_q <= scratch_n;
            in_d      <= in_s;
        end
    end

    assign gpio_out = en ? out_q[GPIO_W-1:0] : '0;
    assign gpio_oeb = en ? oeb_q[GPIO_W-1:0] : '1;

endmodule

// File: tb/tb_team_03_wb_regs.sv
// tb_team_03_wb_regs: directed self-checking bench for team_03_wb_regs.
module tb_team_03_wb_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat = '0;
    logic        ack, err;
    logic [31:0] dat_o;
    logic [33:0] gin = '0, gout, goeb;
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    team_03_wb_regs dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
`ifdef TEAM_03_WB_ERR_EN
        .wbs_err_o (err),
`endif
        .gpio_in   (gin),
        .gpio_out  (gout),
        .gpio_oeb  (goeb)
    );

`ifndef TEAM_03_WB_ERR_EN
    assign err = 1'b0;
`endif

    // One transfer: request held for a single edge, then response sampled in the following cycle.
    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r, output logic a1, output logic a2, output logic e1);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        @(posedge clk);
        @(negedge clk);
        a1 = ack; r = dat_o; e1 = err;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a2 = ack | err;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b expected 0", ack); end
        n_cmp++;
        if (dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h expected 0", dat_o); end
        n_cmp++;
        if (gout !== 34'h0) begin n_fail++; $display("FAIL reset_gpio_out got %h expected 0", gout); end
        n_cmp++;
        if (goeb !== 34'h3_FFFF_FFFF) begin n_fail++; $display("FAIL reset_gpio_oeb got %h expected 3ffffffff", goeb); end
        rst = 1'b0;
    endtask

    task automatic test_scratch;
        logic [31:0] r; logic a1, a2, e1;
        wb(1'b1, 32'h3000_0020, 32'hDEAD_BEEF, 4'b0101, r, a1, a2, e1);
        n_cmp++;
        if (a1 !== 1'b1 || a2 !== 1'b0) begin n_fail++; $display("FAIL scratch_wr_ack got %b%b expected 10", a1, a2); end
        wb(1'b0, 32'h3000_0020, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'h00AD_00EF) begin n_fail++; $display("FAIL scratch_rd got %h expected 00ad00ef", r); end
        n_cmp++;
        if (a1 !== 1'b1) begin n_fail++; $display("FAIL scratch_rd_ack got %b expected 1", a1); end
    endtask

    task automatic test_gpio_out;
        logic [31:0] r; logic a1, a2, e1;
        en = 1'b1;
        wb(1'b1, 32'h3000_0000, 32'h0000_00FF, 4'hF, r, a1, a2, e1);
        wb(1'b1, 32'h3000_0008, 32'hFFFF_FF00, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (gout !== 34'h0_0000_00FF) begin n_fail++; $display("FAIL gpio_out got %h expected 0000000ff", gout); end
        n_cmp++;
        if (goeb !== 34'h3_FFFF_FF00) begin n_fail++; $display("FAIL gpio_oeb got %h expected 3ffffff00", goeb); end
        en = 1'b0;
        #1;
        n_cmp++;
        if (gout !== 34'h0) begin n_fail++; $display("FAIL gpio_out_dis got %h expected 0", gout); end
        n_cmp++;
        if (goeb !== 34'h3_FFFF_FFFF) begin n_fail++; $display("FAIL gpio_oeb_dis got %h expected 3ffffffff", goeb); end
        wb(1'b0, 32'h3000_0008, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'hFFFF_FF00 || a1 !== 1'b1) begin n_fail++; $display("FAIL oeb_rd_dis got %h/%b expected ffffff00/1", r, a1); end
        en = 1'b1;
        #1;
        n_cmp++;
        if (gout !== 34'h0_0000_00FF) begin n_fail++; $display("FAIL gpio_out_re got %h expected 0000000ff", gout); end
        n_cmp++;
        if (goeb !== 34'h3_FFFF_FF00) begin n_fail++; $display("FAIL gpio_oeb_re got %h expected 3ffffff00", goeb); end
        wb(1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 4'hF, r, a1, a2, e1);
        wb(1'b0, 32'h3000_0004, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'h0000_0003) begin n_fail++; $display("FAIL out_hi_rd got %h expected 00000003", r); end
    endtask

    task automatic test_edge;
        logic [31:0] r; logic a1, a2, e1;
        @(negedge clk);
        gin[33] = 1'b1;
        repeat (4) @(posedge clk);
        wb(1'b0, 32'h3000_001C, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'h2) begin n_fail++; $display("FAIL edge_hi got %h expected 2", r); end
        wb(1'b0, 32'h3000_0014, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'h2) begin n_fail++; $display("FAIL in_hi got %h expected 2", r); end
        wb(1'b1, 32'h3000_001C, 32'h2, 4'b1110, r, a1, a2, e1);
        wb(1'b0, 32'h3000_001C, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'h2) begin n_fail++; $display("FAIL edge_hi_masked_clr got %h expected 2", r); end
        wb(1'b1, 32'h3000_001C, 32'h2, 4'hF, r, a1, a2, e1);
        wb(1'b0, 32'h3000_001C, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL edge_hi_clr got %h expected 0", r); end
        wb(1'b0, 32'h3000_0018, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL edge_lo_idle got %h expected 0", r); end
        // Bit 5 rises so its flag sets on the same edge that samples the W1C request.
        @(negedge clk);
        gin[5] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0018; dat = 32'h20; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL race_wr_ack got %b expected 1", ack); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        wb(1'b0, 32'h3000_0018, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'h20) begin n_fail++; $display("FAIL edge_race got %h expected 20", r); end
        wb(1'b0, 32'h3000_0010, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'h20) begin n_fail++; $display("FAIL in_lo got %h expected 20", r); end
    endtask

    task automatic test_decode;
        logic [31:0] r; logic a1, a2, e1;
        int hits = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100; sel = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack !== 1'b0 || err !== 1'b0 || dat_o !== 32'h0) hits++;
        end
        cyc = 1'b0; stb = 1'b0;
        n_cmp++;
        if (hits !== 0) begin n_fail++; $display("FAIL miss_no_resp got %0d responses expected 0", hits); end
        wb(1'b0, 32'h3000_0040, 32'h0, 4'hF, r, a1, a2, e1);
`ifdef TEAM_03_WB_ERR_EN
        n_cmp++;
        if (a1 !== 1'b0 || e1 !== 1'b1 || r !== 32'h0) begin n_fail++; $display("FAIL unmapped got ack=%b err=%b dat=%h expected 0/1/0", a1, e1, r); end
`else
        n_cmp++;
        if (a1 !== 1'b1 || e1 !== 1'b0 || r !== 32'h0) begin n_fail++; $display("FAIL unmapped got ack=%b err=%b dat=%h expected 1/0/0", a1, e1, r); end
`endif
    endtask

    task automatic test_back_to_back;
        logic [31:0] r; logic a1, a2, e1;
        wb(1'b1, 32'h3000_0020, 32'h1234_5678, 4'hF, r, a1, a2, e1);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0020; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (ack !== ((i % 2) == 0) || dat_o !== (((i % 2) == 0) ? 32'h1234_5678 : 32'h0)) begin
                n_fail++;
                $display("FAIL b2b_%0d got ack=%b dat=%h expected ack=%b", i, ack, dat_o, (i % 2) == 0);
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; logic a1, a2, e1;
        @(negedge clk);
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0020; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack got %b expected 0", ack); end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack2 got %b expected 0", ack); end
        wb(1'b0, 32'h3000_0020, 32'h0, 4'hF, r, a1, a2, e1);
        n_cmp++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL rst_mid_scratch got %h expected 0", r); end
        n_cmp++;
        if (gout !== 34'h0 || goeb !== 34'h3_FFFF_FFFF) begin n_fail++; $display("FAIL rst_mid_pads got %h/%h expected 0/3ffffffff", gout, goeb); end
    endtask

    initial begin
        test_reset;
        test_scratch;
        test_gpio_out;
        test_edge;
        test_decode;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/team_03_wb_regs.md
# team_03_wb_regs

Wishbone classic (B4) responder exposing the team_03 GPIO breakout to the Caravel management core. It decodes a 256-byte window and holds memory-mapped output, output-enable, input and edge-capture registers, so firmware can drive and sample the 34 breakout pins. It sits between the user-area Wishbone bus and the team_03 pad signals, and is the bus-facing counterpart of the project's master-side interface.

## Interface
- BASE_ADDR, 32'h3000_0000: window base; only bits [31:8] are compared.
- GPIO_W, 34: pin count; must satisfy 33 ≤ GPIO_W ≤ 64.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  chip enable; when low, pads are forced safe
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  transfer acknowledge
- wbs_dat_o  out  32  read data
- wbs_err_o  out  1  error; present only with TEAM_03_WB_ERR_EN
- gpio_in  in  GPIO_W  pad inputs, asynchronous
- gpio_out  out  GPIO_W  pad outputs
- gpio_oeb  out  GPIO_W  active-low output enable

## Operation
- Hit: wbs_adr_i[31:8] == BASE_ADDR[31:8]. Word offset is adr[7:2]; adr[1:0] are ignored.
- Non-hit: no response. ack, err and dat_o stay 0.
- Register map (HI registers use bits [GPIO_W-33:0]; unused bits read 0):
  - 0x00/0x04 OUT_LO/HI: RW.
  - 0x08/0x0C OEB_LO/HI: RW.
  - 0x10/0x14 IN_LO/HI: RO, synchronized gpio_in.
  - 0x18/0x1C EDGE_LO/HI: rising-edge sticky flags, write-1-to-clear.
  - 0x20 SCRATCH: RW, 32 bits.
- Writes honour wbs_sel_i per byte lane, including on W1C registers. Writes to RO registers are acked and ignored.
- gpio_in passes through a 2-flop synchronizer. An EDGE bit sets when the synchronized bit goes 0→1.
- If an edge set and a W1C clear hit the same bit in the same cycle, the set wins.
- gpio_out = en ? OUT : 0; gpio_oeb = en ? OEB : all-ones. Register contents are kept while en is low.
- The bus stays responsive regardless of en.
- Unmapped offset inside the window (macro absent): read returns 0, write is dropped, ack is normal.

## Timing
- Request: cyc & stb & hit & !ack, sampled at edge N.
- ack pulses high for exactly one cycle, N+1. dat_o is valid in that same cycle and is 0 otherwise.
- Write data is committed on edge N; the new value is readable by a request sampled at edge N+1 or later.
- If stb stays high after ack, that is a new transfer. Peak throughput is 1 transfer per 2 cycles.
- Dropping cyc/stb after edge N does not cancel the transfer: the write stands and ack still pulses.
- IN reflects gpio_in with 2–3 cycles of latency. EDGE sets 1 cycle after the synchronized rise.
- Reset values:
  - ack, err, dat_o: 0.
  - OUT, EDGE, SCRATCH, synchronizers: 0.
  - OEB: all-ones, so gpio_oeb is all-ones and gpio_out is 0.
- rst asserted mid-transfer: the pending ack is squashed and all registers return to reset values on that edge.

## Configuration
- TEAM_03_WB_ERR_EN defined:
  - wbs_err_o port exists.
  - Unmapped in-window offsets get a 1-cycle err pulse instead of ack, with the same timing as ack.
  - dat_o = 0 during err; writes are dropped.
  - ack and err are never high together.
- Undefined: the port is absent and unmapped offsets are acked as described in Operation.

## Structure
- Package team_03_wb_pkg holds:
  - Register offset localparams (OFF_OUT_LO … OFF_SCRATCH).
  - Default BASE_ADDR.
  - A byte-mask helper function expanding sel to a 32-bit mask.
- One sub-module, team_03_sync2: parameterized-width 2-flop synchronizer, reset to 0, used on gpio_in.

## Test plan
- Reset check: assert rst for 2 cycles → ack=0, dat_o=0, gpio_out=0, gpio_oeb=all-ones.
- Write 0xDEADBEEF to 0x3000_0020 with sel=4'b0101 → ack exactly 1 cycle later; SCRATCH reads back 0x00AD00EF.
- Write OUT_LO=0x0000_00FF and OEB_LO=0xFFFF_FF00 with en=1 → gpio_out[7:0]=8'hFF, gpio_oeb[7:0]=0. Then drop en → gpio_out=0 and gpio_oeb=all-ones; raise en → values restored.
- Edge capture:
  - Raise gpio_in[33], wait 4 cycles → read 0x1C = 0x2 and read 0x14 = 0x2.
  - Write 0x2 to 0x1C → EDGE_HI reads 0.
  - Rise on gpio_in[5] landing on the same cycle as a W1C of bit 5 → bit 5 stays 1.
- Address decode:
  - Access to 0x3000_0100 → no ack for 10 cycles.
  - Read of 0x3000_0040 → ack with dat_o=0 (macro off), or err with no ack (macro on).
- Continuous stb with alternating reads of 0x20 → ack every other cycle. Asserting rst during a pending request → no ack follows.
